word_byte_serializer: RTL and testbench
=======================================

// Module: word_byte_serializer
// PURPOSE
//  Transmit side of the 8-bit byte link. Accepts 16-bit words (instructions/data)
//  on a valid/ready port, buffers them in a small FIFO, and emits each word as
//  two bytes, high byte first, on a byte_valid/byte_ack handshake. The receiving
//  16-bit shift assembler rebuilds the word as {first_byte, second_byte}.
// PARAMETERS
//  DEPTH  4  FIFO depth in 16-bit words; power of 2, >= 2
// PORTS
//  clk         in   1               single clock; all state updates on posedge
//  rst_n       in   1               synchronous reset, active-low
//  flush       in   1               sync clear of FIFO + FSM; aborts word in flight
//  word_valid  in   1               upstream word present
//  word_in     in   16              upstream word
//  word_ready  out  1               FIFO can accept (= ~full)
//  byte_out    out  8               current byte on link
//  byte_valid  out  1               byte_out valid
//  byte_ack    in   1               downstream takes byte when byte_valid & byte_ack
//  fifo_count  out  $clog2(DEPTH+1) words in FIFO (excludes word being sent)
//  busy        out  1               FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): FIFO empty, ptrs=0, FSM=IDLE, shift reg=0;
//   outputs byte_out=0, byte_valid=0, word_ready=1, fifo_count=0, busy=0.
//  Push: word_valid & word_ready at posedge writes word_in; no write when full.
//  FSM states: IDLE, SEND_HI, SEND_LO.
//   IDLE: if FIFO non-empty, pop into 16-bit shift reg -> SEND_HI.
//   SEND_HI: byte_valid=1, byte_out=sreg[15:8]; on byte_ack -> SEND_LO.
//   SEND_LO: byte_valid=1, byte_out=sreg[7:0]; on byte_ack: if FIFO non-empty,
//    pop next word same edge -> SEND_HI (no bubble); else -> IDLE.
//  byte_valid/byte_out held stable until acked; IDLE drives byte_valid=0,
//   byte_out=0.
//  Latency: word pushed at edge N into empty FIFO/IDLE -> pop at N+1 ->
//   byte_valid=1 with high byte after edge N+1.
//  Throughput: 1 byte/cycle with byte_ack held high; 2 cycles per word.
//  Simultaneous push+pop: both occur; fifo_count unchanged; when full,
//   word_ready=0 that cycle (no bypass) even if a pop occurs.
//  Pointers log2(DEPTH) bits, wrap mod DEPTH; count separate, saturates never.
//  flush (when rst_n=1): same state as reset next cycle; wins over push, pop,
//   ack. A half-sent word is discarded (receiver realigns by its own reset).
//  byte_ack while byte_valid=0: ignored.
// CONFIGURATION
//  WBS_PARITY_EN defined: adds out port byte_par (1b) = ^byte_out (even parity
//   over the 8 data bits), 0 when byte_valid=0 and at reset; FIFO/FSM unchanged.
//  WBS_PARITY_EN undefined: port byte_par absent; no parity logic.
// TESTING
//  1 Reset: rst_n=0 2 cycles with word_valid=1 -> no push; byte_valid=0,
//    word_ready=1, fifo_count=0, busy=0.
//  2 Single word: push 16'hA55A, byte_ack=1 -> bytes 8'hA5 then 8'h5A on two
//    consecutive cycles, first valid 2 cycles after push; then IDLE, busy=0.
//  3 Back-pressure: push 16'h1234, byte_ack=0 for 5 cycles -> byte_out holds
//    8'h12 with byte_valid=1; ack once -> 8'h34; ack -> IDLE.
//  4 Full/stream: byte_ack=0, push 16'h0001..16'h0005 every cycle -> fifo_count
//    reaches 4 (word 1 in sreg), word_ready=0, 16'h0006 not accepted; then
//    byte_ack=1 -> 00,01,00,02,...,00,05 with no gap bytes.
//  5 Flush mid-word: after 8'hBE of 16'hBEEF acked, flush=1 one cycle with two
//    words queued -> byte_valid=0, fifo_count=0; 8'hEF never sent.
//  6 WBS_PARITY_EN: send 16'h0307 -> byte_par=0 with 8'h03, 1 with 8'h07.

Source files
------------

// File: rtl/word_byte_serializer.sv
// Byte-link transmitter: buffers 16-bit words in a FIFO and sends each as two bytes, high byte first.
// Optional build macro WBS_PARITY_EN adds the byte_par output (even parity of byte_out).
module word_byte_serializer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       word_valid,
   input  logic [15:0]                word_in,
   output logic                       word_ready,
   output logic [7:0]                 byte_out,
   output logic                       byte_valid,
   input  logic                       byte_ack,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
`ifdef WBS_PARITY_EN
   output logic                       busy,
   output logic                       byte_par
`else
   output logic                       busy
`endif
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned WORD_W = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_HI = 2'd1,
      SEND_LO = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   sreg_q, sreg_d;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_d;
   logic [BYTE_W-1:0]   byte_out_d;
   logic                byte_valid_d;
   logic                word_ready_d;
   logic                busy_d;
   logic                push;
   logic                pop;
   logic                fifo_empty;

   // FIFO storage; flush and reset suppress writes, contents need no clearing
   always_ff @(posedge clk) begin
      if (rst_n && !flush && push) begin
         mem[wr_ptr_q] <= word_in;
      end
   end

   // State register plus registered outputs; flush behaves exactly like reset
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_count <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         word_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_count <= count_d;
         byte_out   <= byte_out_d;
         byte_valid <= byte_valid_d;
         word_ready <= word_ready_d;
         busy       <= busy_d;
      end
   end

   // Next-state, FIFO bookkeeping and next output values
   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      pop          = 1'b0;
      byte_out_d   = '0;
      byte_valid_d = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = fifo_count;

      push       = word_valid && word_ready;
      fifo_empty = (fifo_count == '0);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sreg_d  = mem[rd_ptr_q];
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            if (byte_ack) begin
               state_d = SEND_LO;
            end
         end
         SEND_LO: begin
            // Reload straight from the FIFO so a stream has no idle byte slot
            if (byte_ack) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  sreg_d  = mem[rd_ptr_q];
                  state_d = SEND_HI;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = fifo_count + CNT_W'(1);
         2'b01:   count_d = fifo_count - CNT_W'(1);
         default: count_d = fifo_count;
      endcase

      case (state_d)
         SEND_HI: begin
            byte_valid_d = 1'b1;
            byte_out_d   = sreg_d[15:8];
         end
         SEND_LO: begin
            byte_valid_d = 1'b1;
            byte_out_d   = sreg_d[7:0];
         end
         default: begin
            byte_valid_d = 1'b0;
            byte_out_d   = '0;
         end
      endcase

      word_ready_d = (count_d != CNT_W'(DEPTH));
      busy_d       = (state_d != IDLE) || (count_d != '0);
   end

`ifdef WBS_PARITY_EN
   // Even parity tracks the registered byte; zero whenever the link is idle
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         byte_par <= 1'b0;
      end else begin
         byte_par <= byte_valid_d & (^byte_out_d);
      end
   end
`endif

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer with an expected-byte scoreboard.
// Build with WBS_PARITY_EN defined to also exercise byte_par.
module tb_word_byte_serializer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        word_valid;
   logic [15:0] word_in;
   logic        word_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ack;
   logic [2:0]  fifo_count;
   logic        busy;
`ifdef WBS_PARITY_EN
   logic        byte_par;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q [$];

   word_byte_serializer #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .word_valid (word_valid),
      .word_in    (word_in),
      .word_ready (word_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ack   (byte_ack),
      .fifo_count (fifo_count),
`ifdef WBS_PARITY_EN
      .busy       (busy),
      .byte_par   (byte_par)
`else
      .busy       (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Score the handshakes that the coming posedge will complete, then advance one cycle
   task automatic tick();
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         if (byte_valid && byte_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'h0, byte_out}, 32'hFFFF_FFFF);
            end else begin
               chk("byte_stream", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
            end
         end
         if (word_valid && word_ready) begin
            exp_q.push_back(word_in[15:8]);
            exp_q.push_back(word_in[7:0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      chk("drain_timeout_left", exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; word_valid = 1'b1; word_in = 16'hDEAD; byte_ack = 1'b0;
      @(negedge clk);
      // 1: reset with word_valid asserted
      tick(); tick();
      rst_n = 1'b1; word_valid = 1'b0;
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_word_ready", word_ready, 1);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      tick();
      chk("rst_no_push_count", fifo_count, 0);
      chk("rst_no_push_valid", byte_valid, 0);

      // 2: single word, ack held high
      byte_ack = 1'b1; word_valid = 1'b1; word_in = 16'hA55A;
      tick();
      word_valid = 1'b0;
      chk("single_lat_not_yet", byte_valid, 0);
      tick();
      chk("single_first_valid", byte_valid, 1);
      chk("single_hi_byte", byte_out, 8'hA5);
      tick();
      chk("single_lo_byte", byte_out, 8'h5A);
      drain(10);
      chk("single_idle_valid", byte_valid, 0);
      chk("single_idle_busy", busy, 0);

      // 3: back-pressure holds the high byte
      byte_ack = 1'b0; word_valid = 1'b1; word_in = 16'h1234;
      tick();
      word_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", byte_valid, 1);
         chk("bp_hold_byte", byte_out, 8'h12);
         tick();
      end
      byte_ack = 1'b1; tick(); byte_ack = 1'b0;
      chk("bp_lo_byte", byte_out, 8'h34);
      chk("bp_lo_valid", byte_valid, 1);
      tick();
      chk("bp_lo_hold", byte_out, 8'h34);
      byte_ack = 1'b1; tick(); byte_ack = 1'b0;
      chk("bp_idle_valid", byte_valid, 0);
      chk("bp_idle_busy", busy, 0);
      chk("bp_queue_empty", exp_q.size(), 0);

      // 4: fill the FIFO, then stream with no gaps
      for (int i = 1; i <= 5; i++) begin
         word_valid = 1'b1; word_in = 16'(i);
         tick();
      end
      word_in = 16'h0006;
      chk("full_count", fifo_count, 4);
      chk("full_word_ready", word_ready, 0);
      chk("full_busy", busy, 1);
      tick();
      word_valid = 1'b0;
      chk("full_reject_count", fifo_count, 4);
      chk("full_hi_byte", byte_out, 8'h00);
      byte_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("stream_no_gap", byte_valid, 1);
         tick();
      end
      chk("stream_queue_empty", exp_q.size(), 0);
      chk("stream_end_valid", byte_valid, 0);
      chk("stream_end_count", fifo_count, 0);
      chk("stream_end_ready", word_ready, 1);

      // 5: flush after the high byte of 16'hBEEF is taken
      word_valid = 1'b1; word_in = 16'hBEEF; tick();
      word_in = 16'h1111; tick();
      chk("flush_pre_hi", byte_out, 8'hBE);
      word_in = 16'h2222; tick();
      word_valid = 1'b0;
      chk("flush_pre_lo", byte_out, 8'hEF);
      chk("flush_pre_count", fifo_count, 2);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_valid", byte_valid, 0);
      chk("flush_count", fifo_count, 0);
      chk("flush_busy", busy, 0);
      chk("flush_ready", word_ready, 1);
      for (int i = 0; i < 4; i++) begin
         chk("flush_stays_idle", byte_valid, 0);
         tick();
      end

`ifdef WBS_PARITY_EN
      // 6: parity follows the byte and is zero when idle
      chk("par_idle", byte_par, 0);
      byte_ack = 1'b0; word_valid = 1'b1; word_in = 16'h0307; tick();
      word_valid = 1'b0; tick();
      chk("par_hi_byte", byte_out, 8'h03);
      chk("par_hi", byte_par, 0);
      byte_ack = 1'b1; tick(); byte_ack = 1'b0;
      chk("par_lo_byte", byte_out, 8'h07);
      chk("par_lo", byte_par, 1);
      byte_ack = 1'b1; tick();
      chk("par_after", byte_par, 0);
      drain(4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
